// File: rtl/mod_updown_counter.sv
// Modulo up/down counter with load, saturate/wrap mode, wrap pulse,
// and a signed-direction epoch counter with a sticky overflow flag.
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 11,
    parameter int EPOCH_W = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               en,
    input  logic               up_down,
    input  logic               sat_mode,
    input  logic               clr_ovf,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   count,
    output logic               tc,
    output logic               wrap,
    output logic [EPOCH_W-1:0] epoch,
    output logic               ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0]   count_q, count_d;
    logic               wrap_q, wrap_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               ovf_q, ovf_d;
    logic               at_max, at_zero;

    assign at_max  = (count_q == MAX);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        epoch_d = epoch_q;
        ovf_d   = ovf_q & ~clr_ovf;
        if (load) begin
            // Clamp keeps count inside 0..MAX_VAL by construction
            count_d = (data_in > MAX) ? MAX : data_in;
        end else if (en) begin
            if (up_down) begin
                if (!at_max) begin
                    count_d = count_q + WIDTH'(1);
                end else if (!sat_mode) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                    epoch_d = epoch_q + EPOCH_W'(1);
                    if (&epoch_q) ovf_d = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    count_d = count_q - WIDTH'(1);
                end else if (!sat_mode) begin
                    count_d = MAX;
                    wrap_d  = 1'b1;
                    epoch_d = epoch_q - EPOCH_W'(1);
                    if (epoch_q == '0) ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            epoch_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            epoch_q <= epoch_d;
            ovf_q   <= ovf_d;
        end
    end

    // Combinational so a downstream stage can use it as its enable
    assign tc    = en & ~load & (up_down ? at_max : at_zero);
    assign count = count_q;
    assign wrap  = wrap_q;
    assign epoch = epoch_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter: directed steps queue expected
// post-edge state; a monitor pops and compares after every rising edge.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       resetn;
    logic       load, en, up_down, sat_mode, clr_ovf;
    logic [3:0] data_in;
    logic [3:0] count;
    logic       tc, wrap;
    logic [3:0] epoch;
    logic       ovf;

    logic       c_en;
    logic [3:0] lo_cnt, hi_cnt, lo_ep, hi_ep;
    logic       lo_tc, hi_tc, lo_wr, hi_wr, lo_ov, hi_ov;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       wr;
        logic [3:0] ep;
        logic       ov;
        string      nm;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(11), .EPOCH_W(4)) dut (
        .clk(clk), .resetn(resetn), .load(load), .en(en),
        .up_down(up_down), .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .data_in(data_in), .count(count), .tc(tc), .wrap(wrap),
        .epoch(epoch), .ovf(ovf)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(11), .EPOCH_W(4)) u_lo (
        .clk(clk), .resetn(resetn), .load(1'b0), .en(c_en),
        .up_down(1'b1), .sat_mode(1'b0), .clr_ovf(1'b0),
        .data_in(4'd0), .count(lo_cnt), .tc(lo_tc), .wrap(lo_wr),
        .epoch(lo_ep), .ovf(lo_ov)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(11), .EPOCH_W(4)) u_hi (
        .clk(clk), .resetn(resetn), .load(1'b0), .en(lo_tc),
        .up_down(1'b1), .sat_mode(1'b0), .clr_ovf(1'b0),
        .data_in(4'd0), .count(hi_cnt), .tc(hi_tc), .wrap(hi_wr),
        .epoch(hi_ep), .ovf(hi_ov)
    );

    function automatic void chk(exp_t e);
        n_tests++;
        if (count !== e.cnt || tc !== e.tc || wrap !== e.wr ||
            epoch !== e.ep || ovf !== e.ov) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d tc=%0b wrap=%0b ep=%0d ovf=%0b, exp cnt=%0d tc=%0b wrap=%0b ep=%0d ovf=%0b",
                     e.nm, count, tc, wrap, epoch, ovf,
                     e.cnt, e.tc, e.wr, e.ep, e.ov);
        end
    endfunction

    function automatic void chk_val(string nm, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, exp %0d", nm, got, exp);
        end
    endfunction

    // Monitor: the counter presents a new state after every edge
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) chk(q.pop_front());
    end

    task automatic step(input logic ld, input logic e, input logic ud,
                        input logic sat, input logic clr,
                        input logic [3:0] din,
                        input logic [3:0] ec, input logic etc,
                        input logic ew, input logic [3:0] ee,
                        input logic eo, input string nm);
        exp_t x;
        @(negedge clk);
        load = ld; en = e; up_down = ud; sat_mode = sat;
        clr_ovf = clr; data_in = din;
        x.cnt = ec; x.tc = etc; x.wr = ew; x.ep = ee; x.ov = eo; x.nm = nm;
        q.push_back(x);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, exp finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        int hw;
        resetn = 1'b0;
        load = 0; en = 0; up_down = 0; sat_mode = 0; clr_ovf = 0;
        data_in = 0; c_en = 0;
        repeat (2) @(negedge clk);
        r = '{4'd0, 1'b0, 1'b0, 4'd0, 1'b0, "reset"};
        chk(r);
        resetn = 1'b1;

        // ld en ud sat clr din | cnt tc wrap ep ovf
        step(1, 0, 1, 0, 0, 4'd6, 4'd6,  0, 0, 4'd0, 0, "load6");
        step(0, 1, 1, 0, 0, 4'd0, 4'd7,  0, 0, 4'd0, 0, "up7");
        @(negedge clk);
        en = 0;
        #2 resetn = 1'b0;
        #1;
        r = '{4'd0, 1'b0, 1'b0, 4'd0, 1'b0, "async_reset"};
        chk(r);
        @(negedge clk);
        resetn = 1'b1;

        step(1, 0, 0, 0, 0, 4'd1, 4'd1,  0, 0, 4'd0,  0, "load1");
        step(0, 1, 0, 0, 0, 4'd0, 4'd0,  1, 0, 4'd0,  0, "dn0");
        step(0, 1, 0, 0, 0, 4'd0, 4'd11, 0, 1, 4'd15, 1, "dn_wrap");
        step(0, 0, 0, 0, 0, 4'd0, 4'd11, 0, 0, 4'd15, 1, "hold");
        step(1, 0, 0, 1, 0, 4'd1, 4'd1,  0, 0, 4'd15, 1, "load1_sat");
        step(0, 1, 0, 1, 0, 4'd0, 4'd0,  1, 0, 4'd15, 1, "sat_dn0");
        step(0, 1, 0, 1, 0, 4'd0, 4'd0,  1, 0, 4'd15, 1, "sat_hold0a");
        step(0, 1, 0, 1, 0, 4'd0, 4'd0,  1, 0, 4'd15, 1, "sat_hold0b");
        step(0, 0, 0, 0, 1, 4'd0, 4'd0,  0, 0, 4'd15, 0, "clr_ovf");
        step(1, 0, 1, 0, 0, 4'd10, 4'd10, 0, 0, 4'd15, 0, "load10");
        step(0, 1, 1, 0, 0, 4'd0, 4'd11, 1, 0, 4'd15, 0, "up11");
        step(0, 1, 1, 0, 1, 4'd0, 4'd0,  0, 1, 4'd0,  1, "up_wrap_race");
        step(0, 1, 1, 0, 0, 4'd0, 4'd1,  0, 0, 4'd0,  1, "up1");
        step(0, 0, 1, 0, 1, 4'd0, 4'd1,  0, 0, 4'd0,  0, "clr_ovf2");
        step(1, 1, 1, 0, 0, 4'd14, 4'd11, 0, 0, 4'd0, 0, "load_clamp");
        step(0, 0, 1, 0, 0, 4'd0, 4'd11, 0, 0, 4'd0,  0, "idle_a");
        step(0, 0, 1, 0, 0, 4'd0, 4'd11, 0, 0, 4'd0,  0, "idle_b");
        step(0, 1, 0, 0, 0, 4'd0, 4'd10, 0, 0, 4'd0,  0, "dir_dn");
        step(0, 1, 1, 0, 0, 4'd0, 4'd11, 1, 0, 4'd0,  0, "dir_up");
        step(0, 1, 1, 1, 0, 4'd0, 4'd11, 1, 0, 4'd0,  0, "sat_hold11");
        step(1, 0, 1, 0, 0, 4'd11, 4'd11, 0, 0, 4'd0, 0, "load_max");
        step(1, 0, 0, 0, 0, 4'd0, 4'd0,  0, 0, 4'd0,  0, "load0");
        step(0, 0, 0, 0, 0, 4'd0, 4'd0,  0, 0, 4'd0,  0, "idle_c");

        @(negedge clk);
        en = 0;
        repeat (2) @(negedge clk);
        chk_val("queue_drain", q.size(), 0);

        // Cascade: 12 x 12 = 144 edges returns both stages to zero
        hw = 0;
        @(negedge clk);
        c_en = 1'b1;
        for (int i = 0; i < 144; i++) begin
            @(posedge clk);
            #1;
            if (hi_wr) hw++;
        end
        @(negedge clk);
        c_en = 1'b0;
        chk_val("casc_lo_cnt", lo_cnt, 0);
        chk_val("casc_hi_cnt", hi_cnt, 0);
        chk_val("casc_hi_wraps", hw, 1);
        chk_val("casc_hi_epoch", hi_ep, 1);
        chk_val("casc_lo_epoch", lo_ep, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
